// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter: Moore FSM IDLE -> GRANT -> RELEASE -> IDLE.
// Define RR_ARB_TIMEOUT_EN to add a grant hold limit of MAX_HOLD cycles with a timeout pulse.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       areset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("rr_arbiter4: MAX_HOLD must be in 1..255");
    end

    state_t     state_q;
    logic [1:0] ptr_q;
    logic [1:0] gnt_id_q;

    logic       sel_valid_d;
    logic [1:0] sel_id_d;
    logic [1:0] cand_d;
    logic       release_d;
    logic       expire_d;

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_q;
    logic       timeout_q;

    assign expire_d = (hold_q == 8'(MAX_HOLD - 1));
    assign timeout  = timeout_q;
`else
    assign expire_d = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Rotating priority search starting at ptr_q; the first requester found wins.
    always_comb begin
        // NOTE: every signal gets a default before the loop so no path infers a latch.
        sel_valid_d = 1'b0;
        sel_id_d    = ptr_q;
        cand_d      = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand_d = ptr_q + 2'(k);
            if (!sel_valid_d && req[cand_d]) begin
                sel_valid_d = 1'b1;
                sel_id_d    = cand_d;
            end
        end
    end

    assign release_d = done || !req[gnt_id_q];

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            gnt_id_q  <= 2'd0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (sel_valid_d) begin
                        state_q  <= GRANT;
                        gnt_id_q <= sel_id_d;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_q   <= 8'd0;
`endif
                    end
                end
                GRANT: begin
`ifdef RR_ARB_TIMEOUT_EN
                    hold_q <= hold_q + 8'd1;
`endif
                    // A normal release takes precedence over an expiring hold counter.
                    if (release_d) begin
                        state_q <= RELEASE;
                        ptr_q   <= gnt_id_q + 2'd1;
                    end else if (expire_d) begin
                        state_q <= RELEASE;
                        ptr_q   <= gnt_id_q + 2'd1;
`ifdef RR_ARB_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                    end
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = (state_q == GRANT);
    assign gnt    = busy ? (4'b0001 << gnt_id_q) : 4'b0000;
    assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4 with MAX_HOLD=4.
// Covers the timeout path when RR_ARB_TIMEOUT_EN is defined, otherwise checks the unlimited hold.
module tb_rr_arbiter4;

    localparam int unsigned MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       areset;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .areset  (areset),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Observation point: 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        areset = 1'b1;
        req    = 4'b0000;
        done   = 1'b0;
        repeat (2) tick();
        exp = 8'b0000_00_0_0;
        total++;
        if ({gnt, gnt_id, busy, timeout} !== exp) begin
            bad++;
            $display("FAIL reset_held: got %b want %b", {gnt, gnt_id, busy, timeout}, exp);
        end
        areset = 1'b0;
        tick();
        total++;
        if ({gnt, gnt_id, busy, timeout} !== exp) begin
            bad++;
            $display("FAIL reset_idle: got %b want %b", {gnt, gnt_id, busy, timeout}, exp);
        end
    endtask

    // req=0101 held, done after 3 grant cycles: 0,2,0,2 with two zero cycles between grants.
    task automatic test_alternate();
        logic [1:0] id;
        logic [7:0] exp;
        req = 4'b0101;
        for (int g = 0; g < 4; g++) begin
            id = (g % 2 == 0) ? 2'd0 : 2'd2;
            for (int c = 0; c < 3; c++) begin
                tick();
                exp = {4'b0001 << id, id, 1'b1, 1'b0};
                total++;
                if ({gnt, gnt_id, busy, timeout} !== exp) begin
                    bad++;
                    $display("FAIL alt_grant g=%0d c=%0d: got %b want %b", g, c, {gnt, gnt_id, busy, timeout}, exp);
                end
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            if (g == 3) req = 4'b0000;
            for (int z = 0; z < 2; z++) begin
                exp = {4'b0000, id, 1'b0, 1'b0};
                total++;
                if ({gnt, gnt_id, busy, timeout} !== exp) begin
                    bad++;
                    $display("FAIL alt_gap g=%0d z=%0d: got %b want %b", g, z, {gnt, gnt_id, busy, timeout}, exp);
                end
                if (z == 0) tick();
            end
        end
    endtask

    // req=1111, each owner drops its request after one cycle: 0,1,2,3,0.
    task automatic test_wrap();
        logic [1:0] id;
        logic [7:0] exp;
        areset = 1'b1;
        #2;
        areset = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            id = 2'(g % 4);
            tick();
            exp = {4'b0001 << id, id, 1'b1, 1'b0};
            total++;
            if ({gnt, gnt_id, busy, timeout} !== exp) begin
                bad++;
                $display("FAIL wrap_grant g=%0d: got %b want %b", g, {gnt, gnt_id, busy, timeout}, exp);
            end
            req = 4'b1111 & ~(4'b0001 << id);
            tick();
            exp = {4'b0000, id, 1'b0, 1'b0};
            total++;
            if ({gnt, gnt_id, busy, timeout} !== exp) begin
                bad++;
                $display("FAIL wrap_release g=%0d: got %b want %b", g, {gnt, gnt_id, busy, timeout}, exp);
            end
            req = (g == 4) ? 4'b0000 : 4'b1111;
            tick();
        end
    endtask

    // Grant to 1 ignores req[3] toggling; next grant goes to 3.
    task automatic test_ignore_others();
        logic [7:0] exp;
        req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = {4'b0010, 2'd1, 1'b1, 1'b0};
            total++;
            if ({gnt, gnt_id, busy, timeout} !== exp) begin
                bad++;
                $display("FAIL ignore_hold i=%0d: got %b want %b", i, {gnt, gnt_id, busy, timeout}, exp);
            end
            req[3] = ~req[3];
        end
        req = 4'b1000;
        tick();
        exp = {4'b0000, 2'd1, 1'b0, 1'b0};
        total++;
        if ({gnt, gnt_id, busy, timeout} !== exp) begin
            bad++;
            $display("FAIL ignore_release: got %b want %b", {gnt, gnt_id, busy, timeout}, exp);
        end
        repeat (2) tick();
        exp = {4'b1000, 2'd3, 1'b1, 1'b0};
        total++;
        if ({gnt, gnt_id, busy, timeout} !== exp) begin
            bad++;
            $display("FAIL ignore_next: got %b want %b", {gnt, gnt_id, busy, timeout}, exp);
        end
        req = 4'b0000;
        repeat (2) tick();
    endtask

    // Reset mid-grant drops gnt before the next edge; priority restarts at 0.
    task automatic test_async_reset();
        logic [7:0] exp;
        req = 4'b0100;
        tick();
        exp = {4'b0100, 2'd2, 1'b1, 1'b0};
        total++;
        if ({gnt, gnt_id, busy, timeout} !== exp) begin
            bad++;
            $display("FAIL areset_pre: got %b want %b", {gnt, gnt_id, busy, timeout}, exp);
        end
        #2;
        areset = 1'b1;
        #1;
        exp = 8'b0000_00_0_0;
        total++;
        if ({gnt, gnt_id, busy, timeout} !== exp) begin
            bad++;
            $display("FAIL areset_async: got %b want %b", {gnt, gnt_id, busy, timeout}, exp);
        end
        tick();
        areset = 1'b0;
        req    = 4'b1100;
        tick();
        exp = {4'b0100, 2'd2, 1'b1, 1'b0};
        total++;
        if ({gnt, gnt_id, busy, timeout} !== exp) begin
            bad++;
            $display("FAIL areset_first_arb: got %b want %b", {gnt, gnt_id, busy, timeout}, exp);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0000;
        tick();
    endtask

    // done in IDLE with no requests changes nothing, including the pointer (3 after grant 2).
    task automatic test_done_idle();
        logic [7:0] exp;
        done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = {4'b0000, 2'd2, 1'b0, 1'b0};
            total++;
            if ({gnt, gnt_id, busy, timeout} !== exp) begin
                bad++;
                $display("FAIL done_idle i=%0d: got %b want %b", i, {gnt, gnt_id, busy, timeout}, exp);
            end
        end
        done = 1'b0;
        req  = 4'b1111;
        tick();
        exp = {4'b1000, 2'd3, 1'b1, 1'b0};
        total++;
        if ({gnt, gnt_id, busy, timeout} !== exp) begin
            bad++;
            $display("FAIL done_idle_ptr: got %b want %b", {gnt, gnt_id, busy, timeout}, exp);
        end
        req = 4'b0000;
        repeat (2) tick();
    endtask

`ifdef RR_ARB_TIMEOUT_EN
    // MAX_HOLD=4: four busy cycles then a one-cycle timeout; done on the 4th cycle wins.
    task automatic test_timeout();
        logic [7:0] exp;
        areset = 1'b1;
        #2;
        areset = 1'b0;
        req    = 4'b0001;
        done   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            exp = {4'b0001, 2'd0, 1'b1, 1'b0};
            total++;
            if ({gnt, gnt_id, busy, timeout} !== exp) begin
                bad++;
                $display("FAIL to_hold c=%0d: got %b want %b", c, {gnt, gnt_id, busy, timeout}, exp);
            end
        end
        tick();
        exp = {4'b0000, 2'd0, 1'b0, 1'b1};
        total++;
        if ({gnt, gnt_id, busy, timeout} !== exp) begin
            bad++;
            $display("FAIL to_pulse: got %b want %b", {gnt, gnt_id, busy, timeout}, exp);
        end
        tick();
        exp = {4'b0000, 2'd0, 1'b0, 1'b0};
        total++;
        if ({gnt, gnt_id, busy, timeout} !== exp) begin
            bad++;
            $display("FAIL to_pulse_end: got %b want %b", {gnt, gnt_id, busy, timeout}, exp);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            exp = {4'b0001, 2'd0, 1'b1, 1'b0};
            total++;
            if ({gnt, gnt_id, busy, timeout} !== exp) begin
                bad++;
                $display("FAIL to_regrant c=%0d: got %b want %b", c, {gnt, gnt_id, busy, timeout}, exp);
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0000;
        exp = {4'b0000, 2'd0, 1'b0, 1'b0};
        total++;
        if ({gnt, gnt_id, busy, timeout} !== exp) begin
            bad++;
            $display("FAIL to_done_wins: got %b want %b", {gnt, gnt_id, busy, timeout}, exp);
        end
        tick();
    endtask
`else
    // Without the timeout option a grant lasts until released and timeout stays 0.
    task automatic test_timeout();
        logic [7:0] exp;
        areset = 1'b1;
        #2;
        areset = 1'b0;
        req    = 4'b0001;
        done   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            exp = {4'b0001, 2'd0, 1'b1, 1'b0};
            total++;
            if ({gnt, gnt_id, busy, timeout} !== exp) begin
                bad++;
                $display("FAIL nto_hold c=%0d: got %b want %b", c, {gnt, gnt_id, busy, timeout}, exp);
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0000;
        exp = {4'b0000, 2'd0, 1'b0, 1'b0};
        total++;
        if ({gnt, gnt_id, busy, timeout} !== exp) begin
            bad++;
            $display("FAIL nto_release: got %b want %b", {gnt, gnt_id, busy, timeout}, exp);
        end
        tick();
    endtask
`endif

    initial begin
        areset = 1'b1;
        req    = 4'b0000;
        done   = 1'b0;
        test_reset();
        test_alternate();
        test_wrap();
        test_ignore_others();
        test_async_reset();
        test_done_idle();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
